// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned AW_DEF           = 16;
  localparam int unsigned DW_DEF           = 16;
  localparam int unsigned DEPTH_DEF        = 64;
  localparam int unsigned MAX_BURST_DEF    = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Bits needed to hold the values 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  localparam int unsigned BURST_CW = cnt_width(MAX_BURST_DEF);
  localparam int unsigned WAIT_CW  = cnt_width(STARVE_LIMIT_DEF);

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over enable.
module sat_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA port:
// CPU priority, bounded DMA burst lock, and a starvation guarantee for DMA.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned MAX_BURST    = MAX_BURST_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_burst,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD,
  output logic          addr_err
);

  localparam int unsigned BW = cnt_width(MAX_BURST);
  localparam int unsigned WW = cnt_width(STARVE_LIMIT);
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  arb_state_e    state;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic          starved;
  logic          cpu_legal;
  logic          dma_legal;
  logic          burst_en;
  logic          burst_done;
  logic          wait_en;
  logic          wait_clr;
  logic          err_now;

  assign starved   = (wait_cnt == WW'(STARVE_LIMIT));
  assign cpu_legal = ({1'b0, cpu_addr} < DEPTH_EXT);
  assign dma_legal = ({1'b0, dma_addr} < DEPTH_EXT);

  always_comb begin
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    if (!RST) begin
      if (state == DMA_BURST) begin
        dma_ack = dma_req;
      end else if (dma_req && (starved || !cpu_req)) begin
        dma_ack = 1'b1;
      end else begin
        cpu_ack = cpu_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = (cpu_ack && cpu_legal) ? mem_RD : '0;
  assign dma_rdata = (dma_ack && dma_legal) ? mem_RD : '0;

  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    if (cpu_ack) begin
      mem_A  = cpu_addr;
      mem_WD = cpu_wdata;
      mem_WE = cpu_we & cpu_legal;
    end else if (dma_ack) begin
      mem_A  = dma_addr;
      mem_WD = dma_wdata;
      mem_WE = dma_we & dma_legal;
    end
  end

  // burst_cnt idles at 0, so counting the locking access as an increment yields 1 on entry.
  assign burst_en   = dma_ack && ((state == DMA_BURST) || dma_burst);
  assign burst_done = (state == DMA_BURST) &&
                      (!dma_req || !dma_burst || (burst_cnt >= BW'(MAX_BURST - 1)));

  assign wait_en  = dma_req & ~dma_ack;
  assign wait_clr = ~dma_req | dma_ack;

  assign err_now = (cpu_ack && !cpu_legal) || (dma_ack && !dma_legal);

  sat_counter #(.MAX(MAX_BURST), .W(BW)) u_burst_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (burst_done),
    .en    (burst_en),
    .count (burst_cnt)
  );

  sat_counter #(.MAX(STARVE_LIMIT), .W(WW)) u_wait_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (wait_clr),
    .en    (wait_en),
    .count (wait_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      addr_err <= 1'b0;
    end else begin
      case (state)
        IDLE:      if (dma_ack && dma_burst) state <= DMA_BURST;
        DMA_BURST: if (burst_done) state <= IDLE;
        default:   state <= IDLE;
      endcase
      if (err_now) addr_err <= 1'b1;
    end
  end

endmodule
